// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the dual-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefDataWidth = 8;

  // Requester index width; a single requester still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer and wraps; pointer moves past the winner.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] valid,
  input  logic              advance,
  output logic [NumReq-1:0] grant,
  output logic [IdW-1:0]    winner
);

  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [NumReq-1:0] rot;
  logic [IdW-1:0]    offset;
  logic [IdW:0]      sum;
  logic              found;

  always_comb begin
    // Rotate so bit 0 is the pointer position, then take the lowest set bit.
    rot    = NumReq'({valid, valid} >> ptr_q);
    found  = 1'b0;
    offset = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!found && rot[k]) begin
        found  = 1'b1;
        offset = IdW'(k);
      end
    end
    sum    = {1'b0, ptr_q} + {1'b0, offset};
    winner = (sum >= (IdW+1)'(NumReq)) ? IdW'(sum - (IdW+1)'(NumReq)) : IdW'(sum);
    grant  = found ? (NumReq'(1) << winner) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (winner == IdW'(NumReq - 1)) ? '0 : winner + IdW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Clears the RAM after reset, then round-robin shares its write and read ports among requesters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH,
  localparam int unsigned IdW       = id_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_wr_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wr_data,
  output logic [NUM_REQ-1:0]             req_wr_ready,
  input  logic [NUM_REQ-1:0]             req_rd_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_rd_addr,
  output logic [NUM_REQ-1:0]             req_rd_ready,
  output logic                           rsp_valid,
  output logic [IdW-1:0]                 rsp_id,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           init_done,
  output logic                           wr_enb,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           rd_enb,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic [DATA_WIDTH-1:0]          rd_data
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  wr_enb_q, wr_enb_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_enb_q, rd_enb_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [IdW-1:0]        rd_id_q, rd_id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]        rsp_id_q, rsp_id_d;

  logic                  run, hazard, rd_advance;
  logic [NUM_REQ-1:0]    wr_grant, rd_grant;
  logic [IdW-1:0]        wr_win, rd_win;
  logic [ADDR_WIDTH-1:0] wr_addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] wr_data_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] rd_addr_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] wr_sel_addr, rd_sel_addr;
  logic [DATA_WIDTH-1:0] wr_sel_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : gen_unpack
    assign wr_addr_arr[g] = req_wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_arr[g] = req_wr_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign rd_addr_arr[g] = req_rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdW    (IdW)
  ) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_wr_valid),
    .advance (run),
    .grant   (wr_grant),
    .winner  (wr_win)
  );

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdW    (IdW)
  ) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_rd_valid),
    .advance (rd_advance),
    .grant   (rd_grant),
    .winner  (rd_win)
  );

  assign run         = (state_q == ST_RUN);
  assign wr_sel_addr = wr_addr_arr[wr_win];
  assign wr_sel_data = wr_data_arr[wr_win];
  assign rd_sel_addr = rd_addr_arr[rd_win];

  // A same-address read waits one cycle so it observes the new write.
  assign hazard     = run && (|wr_grant) && (|rd_grant) && (wr_sel_addr == rd_sel_addr);
  assign rd_advance = run && !hazard;

  assign req_wr_ready = run ? wr_grant : '0;
  assign req_rd_ready = rd_advance ? rd_grant : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q | run;
    wr_enb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    unique case (state_q)
      ST_INIT: begin
        wr_enb_d  = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = '0;
        cnt_d     = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (|wr_grant) begin
          wr_enb_d  = 1'b1;
          wr_addr_d = wr_sel_addr;
          wr_data_d = wr_sel_data;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    rd_enb_d    = rd_advance && (|rd_grant);
    rd_addr_d   = rd_enb_d ? rd_sel_addr : rd_addr_q;
    rd_id_d     = rd_enb_d ? rd_win : rd_id_q;
    rsp_valid_d = rd_enb_q;
    rsp_id_d    = rd_enb_q ? rd_id_q : rsp_id_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      wr_enb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_enb_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      wr_enb_q    <= wr_enb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_enb_q    <= rd_enb_d;
      rd_addr_q   <= rd_addr_d;
      rd_id_q     <= rd_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign init_done = init_done_q;
  assign wr_enb    = wr_enb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_enb    = rd_enb_q;
  assign rd_addr   = rd_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rd_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM behind it.
module tb_ram_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_wr_valid, req_wr_ready, req_rd_valid, req_rd_ready;
  logic [NR*AW-1:0] req_wr_addr, req_rd_addr;
  logic [NR*DW-1:0] req_wr_data;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_data;
  logic             init_done, wr_enb, rd_enb;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [DW-1:0]    wr_data, rd_data;
  logic [DW-1:0]    mem [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] wv;
    logic [3:0] rv;
    logic [3:0] exp_wr;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t tbl [11];

  ram_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_wr_valid (req_wr_valid),
    .req_wr_addr  (req_wr_addr),
    .req_wr_data  (req_wr_data),
    .req_wr_ready (req_wr_ready),
    .req_rd_valid (req_rd_valid),
    .req_rd_addr  (req_rd_addr),
    .req_rd_ready (req_rd_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .init_done    (init_done),
    .wr_enb       (wr_enb),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_enb       (rd_enb),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_enb) mem[wr_addr] <= wr_data;
    if (rd_enb) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int b = 0; b < 4; b++) if (v[b]) r = 2'(b);
    return r;
  endfunction

  initial begin
    logic [3:0] prev_w, prev_r1, prev_r2;

    tbl[0]  = '{wv: 4'b0000, rv: 4'b1000, exp_wr: 4'b0000, exp_rd: 4'b1000};
    tbl[1]  = '{wv: 4'b1111, rv: 4'b1111, exp_wr: 4'b1000, exp_rd: 4'b0001};
    tbl[2]  = '{wv: 4'b0110, rv: 4'b1111, exp_wr: 4'b0010, exp_rd: 4'b0010};
    tbl[3]  = '{wv: 4'b0011, rv: 4'b1111, exp_wr: 4'b0001, exp_rd: 4'b0100};
    tbl[4]  = '{wv: 4'b0011, rv: 4'b1111, exp_wr: 4'b0010, exp_rd: 4'b1000};
    tbl[5]  = '{wv: 4'b0000, rv: 4'b1111, exp_wr: 4'b0000, exp_rd: 4'b0001};
    tbl[6]  = '{wv: 4'b1100, rv: 4'b1111, exp_wr: 4'b0100, exp_rd: 4'b0010};
    tbl[7]  = '{wv: 4'b1001, rv: 4'b1111, exp_wr: 4'b1000, exp_rd: 4'b0100};
    tbl[8]  = '{wv: 4'b1001, rv: 4'b1111, exp_wr: 4'b0001, exp_rd: 4'b1000};
    tbl[9]  = '{wv: 4'b0000, rv: 4'b0000, exp_wr: 4'b0000, exp_rd: 4'b0000};
    tbl[10] = '{wv: 4'b0000, rv: 4'b0000, exp_wr: 4'b0000, exp_rd: 4'b0000};

    // Reset with every requester asking.
    rst          = 1'b1;
    req_wr_valid = '1;
    req_rd_valid = '1;
    req_wr_addr  = '0;
    req_rd_addr  = '0;
    req_wr_data  = '1;
    tick();
    tick();
    chk("rst_wr_ready", 32'(req_wr_ready), 32'h0);
    chk("rst_rd_ready", 32'(req_rd_ready), 32'h0);
    chk("rst_wr_enb", 32'(wr_enb), 32'h0);
    chk("rst_rd_enb", 32'(rd_enb), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_rd_addr", 32'(rd_addr), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    rst = 1'b0;

    // Memory clear sequence.
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("init_wr_ready", 32'(req_wr_ready), 32'h0);
      chk("init_rd_ready", 32'(req_rd_ready), 32'h0);
      chk("init_wr_enb", 32'(wr_enb), 32'(k > 0));
      if (k > 0) begin
        chk("init_wr_addr", 32'(wr_addr), 32'(k - 1));
        chk("init_wr_data", 32'(wr_data), 32'h0);
      end
      chk("init_done_low", 32'(init_done), 32'h0);
      tick();
    end
    req_wr_valid = '0;
    req_rd_valid = '0;
    #1;
    chk("init_last_enb", 32'(wr_enb), 32'h1);
    chk("init_last_addr", 32'(wr_addr), 32'hf);
    chk("init_done_16", 32'(init_done), 32'h0);
    tick();
    chk("init_done_17", 32'(init_done), 32'h1);
    chk("idle_wr_enb", 32'(wr_enb), 32'h0);

    // Single write then read-back by requester 2.
    req_wr_addr[2*AW +: AW] = 4'd5;
    req_wr_data[2*DW +: DW] = 8'ha5;
    req_wr_valid = 4'b0100;
    #1;
    chk("w2_ready", 32'(req_wr_ready), 32'h4);
    tick();
    req_wr_valid = '0;
    chk("w2_wr_enb", 32'(wr_enb), 32'h1);
    chk("w2_wr_addr", 32'(wr_addr), 32'h5);
    chk("w2_wr_data", 32'(wr_data), 32'ha5);
    req_rd_addr[2*AW +: AW] = 4'd5;
    req_rd_valid = 4'b0100;
    #1;
    chk("r2_ready", 32'(req_rd_ready), 32'h4);
    tick();
    req_rd_valid = '0;
    chk("r2_rd_enb", 32'(rd_enb), 32'h1);
    chk("r2_rd_addr", 32'(rd_addr), 32'h5);
    chk("r2_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    chk("r2_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("r2_rsp_id", 32'(rsp_id), 32'h2);
    chk("r2_rsp_data", 32'(rsp_data), 32'ha5);
    tick();
    chk("r2_rsp_done", 32'(rsp_valid), 32'h0);

    // Table: round-robin rotation on both ports.
    for (int i = 0; i < NR; i++) begin
      req_wr_addr[i*AW +: AW] = AW'(i);
      req_wr_data[i*DW +: DW] = DW'(8'h10 + i);
      req_rd_addr[i*AW +: AW] = AW'(10 + i);
    end
    for (int i = 0; i < 11; i++) begin
      req_wr_valid = tbl[i].wv;
      req_rd_valid = tbl[i].rv;
      #1;
      chk("tbl_wr_ready", 32'(req_wr_ready), 32'(tbl[i].exp_wr));
      chk("tbl_rd_ready", 32'(req_rd_ready), 32'(tbl[i].exp_rd));
      prev_w  = (i > 0) ? tbl[i-1].exp_wr : 4'b0000;
      prev_r1 = (i > 0) ? tbl[i-1].exp_rd : 4'b0000;
      prev_r2 = (i > 1) ? tbl[i-2].exp_rd : 4'b0000;
      chk("tbl_wr_enb", 32'(wr_enb), 32'(|prev_w));
      if (|prev_w) begin
        chk("tbl_wr_addr", 32'(wr_addr), 32'(oh2idx(prev_w)));
        chk("tbl_wr_data", 32'(wr_data), 32'h10 + 32'(oh2idx(prev_w)));
      end
      chk("tbl_rd_enb", 32'(rd_enb), 32'(|prev_r1));
      if (|prev_r1) chk("tbl_rd_addr", 32'(rd_addr), 32'd10 + 32'(oh2idx(prev_r1)));
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'(|prev_r2));
      if (|prev_r2) begin
        chk("tbl_rsp_id", 32'(rsp_id), 32'(oh2idx(prev_r2)));
        chk("tbl_rsp_data", 32'(rsp_data), 32'h0);
      end
      tick();
    end

    // Same-address write and read in one cycle: read deferred by one cycle.
    req_wr_addr[0*AW +: AW] = 4'd9;
    req_wr_data[0*DW +: DW] = 8'h3c;
    req_rd_addr[1*AW +: AW] = 4'd9;
    req_wr_valid = 4'b0001;
    req_rd_valid = 4'b0010;
    #1;
    chk("haz_wr_ready", 32'(req_wr_ready), 32'h1);
    chk("haz_rd_held", 32'(req_rd_ready), 32'h0);
    tick();
    req_wr_valid = '0;
    #1;
    chk("haz_rd_ready", 32'(req_rd_ready), 32'h2);
    chk("haz_rd_enb0", 32'(rd_enb), 32'h0);
    tick();
    req_rd_valid = '0;
    chk("haz_rd_enb", 32'(rd_enb), 32'h1);
    chk("haz_rd_addr", 32'(rd_addr), 32'h9);
    tick();
    chk("haz_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("haz_rsp_id", 32'(rsp_id), 32'h1);
    chk("haz_rsp_data", 32'(rsp_data), 32'h3c);
    tick();

    // Reset right after a read grant drops the response and re-clears memory.
    req_rd_addr[0*AW +: AW] = 4'd5;
    req_rd_valid = 4'b0001;
    #1;
    chk("rr_rd_ready", 32'(req_rd_ready), 32'h1);
    tick();
    req_rd_valid = '0;
    rst = 1'b1;
    chk("rr_rd_enb", 32'(rd_enb), 32'h1);
    tick();
    chk("rr_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rr_rd_enb_clr", 32'(rd_enb), 32'h0);
    chk("rr_init_done", 32'(init_done), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k <= 2) chk("rr_no_rsp", 32'(rsp_valid), 32'h0);
      if (k == 1) chk("rr_init_addr0", 32'(wr_addr), 32'h0);
      chk("rr_init_done_k", 32'(init_done), 32'(k == 17));
    end
    req_rd_addr[3*AW +: AW] = 4'd5;
    req_rd_valid = 4'b1000;
    #1;
    chk("rr_ptr_reset", 32'(req_rd_ready), 32'h8);
    tick();
    req_rd_valid = '0;
    tick();
    chk("rr_rsp_valid2", 32'(rsp_valid), 32'h1);
    chk("rr_rsp_id2", 32'(rsp_id), 32'h3);
    chk("rr_rsp_cleared", 32'(rsp_data), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Controller that sits in front of the dual-port RAM and shares its write port and its read port between NUM_REQ requesters.
- After reset it sequences a full-memory clear (INIT). It then runs independent round-robin arbitration on each port.
- It returns read data to the requester that issued the read, tagged by requester index.
- It is the only driver of the RAM's wr_enb/wr_addr/wr_data/rd_enb/rd_addr.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- DEPTH, 2**ADDR_WIDTH, RAM words. Derived; do not override.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_wr_valid  input  NUM_REQ  per-requester write request.
- req_wr_addr  input  NUM_REQ x ADDR_WIDTH  write address per requester.
- req_wr_data  input  NUM_REQ x DATA_WIDTH  write data per requester.
- req_wr_ready  output  NUM_REQ  write grant, one-hot or zero.
- req_rd_valid  input  NUM_REQ  per-requester read request.
- req_rd_addr  input  NUM_REQ x ADDR_WIDTH  read address per requester.
- req_rd_ready  output  NUM_REQ  read grant, one-hot or zero.
- rsp_valid  output  1  read data valid.
- rsp_id  output  $clog2(NUM_REQ)  requester index that owns rsp_data.
- rsp_data  output  DATA_WIDTH  read data.
- init_done  output  1  high once the memory clear has completed.
- wr_enb, wr_addr, wr_data  output  1/ADDR_WIDTH/DATA_WIDTH  to the RAM write port (registered).
- rd_enb, rd_addr  output  1/ADDR_WIDTH  to the RAM read port (registered).
- rd_data  input  DATA_WIDTH  from the RAM; valid one cycle after rd_enb.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to INIT and the init counter goes to 0.
  - wr_enb, rd_enb, rsp_valid and init_done are 0. wr_addr, wr_data, rd_addr and rsp_id are 0.
  - Both round-robin pointers go to 0. Any in-flight read is discarded and no rsp_valid is produced for it.
- Reset priority: a reset applied mid-operation has the same effect and restarts INIT.
- FSM states: INIT and RUN.
- INIT:
  - req_wr_ready and req_rd_ready are all 0.
  - Each cycle: wr_enb=1, wr_addr=cnt, wr_data=0, then cnt increments.
  - After the write of address DEPTH-1, the FSM moves to RUN and init_done rises. init_done is first high DEPTH+1 cycles after reset deasserts.
  - init_done stays high until the next reset.
- RUN: no state exit except reset.
- Handshake:
  - A transfer occurs on a cycle where valid[i] and ready[i] are both 1.
  - ready is combinational from the valids, the FSM state and the pointer.
  - A requester holds valid, addr and data stable until it sees ready.
  - ready never depends on ready.
- Arbitration:
  - Write and read ports each use their own round-robin pointer.
  - The search starts at the pointer index and wraps modulo NUM_REQ. The first asserted valid wins.
  - After a grant, the pointer is set to (winner+1) mod NUM_REQ. With no grant, the pointer holds.
- Write path: a grant in cycle T produces wr_enb=1 with the granted addr/data in T+1. With no grant, wr_enb=0 in T+1.
- Read path:
  - A grant in cycle T produces rd_enb=1 and rd_addr in T+1.
  - rsp_valid=1, rsp_id=winner and rsp_data=rd_data in T+2.
  - rsp_data passes rd_data through combinationally. One read can be granted per cycle, so back-to-back responses are possible.
- Hazard: in a cycle where both the write winner and the read winner target the same address, the read grant is withheld (req_rd_ready all 0) and the read pointer does not advance. The read is granted on the next cycle and returns the newly written data.
- No output depends combinationally on rsp_* inputs; there is no backpressure on responses.

Decomposition:
- Shared package ram_arb_pkg holds:
  - the state enum (ST_INIT, ST_RUN);
  - the default ADDR_WIDTH/DATA_WIDTH/NUM_REQ constants;
  - the id width function.
- Sub-module rr_arbiter (NUM_REQ parameter; inputs clk, rst, valid, advance; outputs grant one-hot and winner index). It is instantiated twice, once per port.

Test Plan:
- Release reset with all valids high -> ready=0 for 16 cycles; wr_enb=1 with wr_addr 0..15 and wr_data=0; init_done=1 on cycle 17.
- RUN, only req 2 writes addr 5 data 0xA5 at T -> wr_enb=1, wr_addr=5, wr_data=0xA5 at T+1. Req 2 then reads addr 5 -> rsp_valid=1, rsp_id=2, rsp_data=0xA5 two cycles after its grant.
- All 4 read valids held high for 8 cycles -> grants rotate in the order 0,1,2,3,0,1,2,3 and rsp_id follows the same order, 2 cycles behind.
- Req 0 writes 0x3C to addr 9 while req 1 reads addr 9 in the same cycle -> read grant delayed by 1 cycle; rsp_data=0x3C.
- Read granted, then rst asserted the next cycle -> no rsp_valid; INIT restarts from addr 0; a later read of the previously written address returns 0.
